fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
- REQ-001: Parameter RESET_PC, default 32'h0040_0000, is the first fetch address after reset.
- REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: imem_req_valid  output  1  fetch request to instruction memory.
- REQ-005: imem_req_addr  output  32  word-aligned fetch address.
- REQ-006: imem_req_ready  input  1  memory accepts the request this cycle.
- REQ-007: imem_rsp_valid  input  1  instruction word returned.
- REQ-008: imem_rsp_data  input  32  instruction word.
- REQ-009: redirect_valid  input  1  resolved jump/branch/jr target from next-instruction calculation.
- REQ-010: redirect_addr  input  32  new fetch address.
- REQ-011: out_valid  output  1  instruction available to decode.
- REQ-012: out_ready  input  1  decode accepts the instruction.
- REQ-013: out_instr  output  32  fetched instruction.
- REQ-014: out_pc_plus4  output  32  fetch address + 4 of out_instr, feeds Instr_PC_Plus4.
- REQ-015: redirect_misaligned  output  1  one-cycle pulse when redirect_addr[1:0] != 0.

Function
- REQ-016: The block SHALL implement states REQ, WAIT, HOLD, with at most one outstanding memory request.
- REQ-017: REQ: imem_req_valid = 1 and imem_req_addr = pc; the address SHALL stay stable until accepted; imem_req_valid & imem_req_ready -> WAIT.
- REQ-018: WAIT: imem_req_valid = 0; on imem_rsp_valid with discard = 0, the block SHALL load out_instr <= imem_rsp_data, out_pc_plus4 <= pc + 4, out_valid <= 1, pc <= pc + 4, then -> HOLD.
- REQ-019: HOLD: out_valid stays 1 and out_instr/out_pc_plus4 stay stable until out_valid & out_ready; on that handshake out_valid <= 0 and -> REQ, so a new request is issued the next cycle.
- REQ-020: Steady-state throughput SHALL be one instruction per 3 cycles with zero-latency memory and out_ready = 1.
- REQ-021: pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- REQ-022: redirect_valid SHALL take priority over every other event: pc <= {redirect_addr[31:2], 2'b00}, out_valid <= 0.
- REQ-023: Redirect in REQ with no handshake that cycle: the block SHALL stay in REQ and present the new address next cycle.
- REQ-024: Redirect in REQ coinciding with imem_req_ready: the accepted request is stale; the block SHALL set discard and go to WAIT.
- REQ-025: Redirect in WAIT without imem_rsp_valid: the block SHALL set discard and stay in WAIT.
- REQ-026: Redirect in WAIT coinciding with imem_rsp_valid: the response SHALL be dropped and the block SHALL go to REQ.
- REQ-027: Redirect in HOLD: the held instruction SHALL be dropped, even if out_ready = 1 that cycle, and the block SHALL go to REQ.
- REQ-028: In WAIT with discard = 1, imem_rsp_valid SHALL clear discard, leave the outputs unchanged and go to REQ.
- REQ-029: redirect_misaligned SHALL pulse the cycle after a redirect whose redirect_addr[1:0] != 0; the fetch address is still forced aligned.
- REQ-030: imem_rsp_valid in REQ or HOLD is a protocol error and SHALL be ignored.

Reset
- REQ-031: While rst_n = 0: state = REQ, pc = RESET_PC, discard = 0, out_valid = 0, out_instr = 0, out_pc_plus4 = 0, redirect_misaligned = 0.
- REQ-032: imem_req_valid SHALL be 0 while rst_n = 0, and 1 from the first rising edge after release.
- REQ-033: Reset asserted mid-transaction SHALL abandon it; any late response is never forwarded, because the block is in REQ.

Structure
- REQ-034: State encodings and RESET_PC default SHALL live in the shared config include.
- REQ-035: The output holding register (out_instr, out_pc_plus4, out_valid with valid/ready hold) SHALL be a sub-module named fetch_hold_reg.

Verification
- REQ-036: Reset release with memory ready and 1-cycle response -> first request addr 0x00400000, out_instr equal to the memory word, out_pc_plus4 = 0x00400004.
- REQ-037: out_ready = 0 for 5 cycles in HOLD -> out_instr stable, no new request, and the next address 0x00400004 is issued one cycle after out_ready rises.
- REQ-038: Redirect to 0x00400100 in WAIT, response arrives 2 cycles later -> response dropped, out_valid never asserted for it, next request addr 0x00400100.
- REQ-039: Redirect to 0x00400200 in the same cycle as imem_req_ready -> following response discarded, next request addr 0x00400200.
- REQ-040: Redirect to 0x00400203 -> redirect_misaligned pulses once, request addr 0x00400200.
- REQ-041: pc = 0xFFFFFFFC fetch -> out_pc_plus4 = 0x00000000, next request addr 0x00000000; rst_n pulsed low in WAIT -> out_valid = 0, addr returns to 0x00400000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared configuration for the fetch sequencer: state encodings, reset PC
// and the address-alignment helper.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Output holding register: captures a fetched instruction and holds it
// until decode takes it; a flush drops it regardless of out_ready.
module fetch_hold_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc_plus4,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc_plus4
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;

   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d    = 1'b1;
         instr_d    = load_instr;
         pc_plus4_d = load_pc_plus4;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         pc_plus4_q <= 32'h0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_instr    = instr_q;
   assign out_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding request, redirect has priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_REQ  | request pc from memory, hold address until accepted
// ST_WAIT | request accepted, waiting for response (discard if stale)
// ST_HOLD | instruction presented to decode until out_ready
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc_plus4,
   output logic        redirect_misaligned
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         discard_q, discard_d;
   logic         misaligned_q, misaligned_d;
   logic         req_en_q;
   logic         hold_load;
   logic         req_fire;
   logic [31:0]  pc_plus4;

   // Keeps the request low between reset release and the first clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) req_en_q <= 1'b0;
      else        req_en_q <= 1'b1;
   end

   assign imem_req_valid = (state_q == ST_REQ) && req_en_q;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign pc_plus4       = pc_q + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      discard_d    = discard_q;
      hold_load    = 1'b0;
      misaligned_d = redirect_valid && (redirect_addr[1:0] != 2'b00);
      case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = align_word(redirect_addr);
               if (req_fire) begin
                  discard_d = 1'b1;
                  state_d   = ST_WAIT;
               end
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d = align_word(redirect_addr);
               if (imem_rsp_valid) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  hold_load = 1'b1;
                  pc_d      = pc_plus4;
                  state_d   = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = align_word(redirect_addr);
               state_d = ST_REQ;
            end else if (out_valid && out_ready) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         discard_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         discard_q    <= discard_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign redirect_misaligned = misaligned_q;

   fetch_hold_reg u_hold (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (hold_load),
      .flush         (redirect_valid),
      .load_instr    (imem_rsp_data),
      .load_pc_plus4 (pc_plus4),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc_plus4  (out_pc_plus4)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle-vector table plus hand sequences
// for stall, address wrap and mid-transaction reset.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic        redirect_misaligned;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .imem_req_valid      (imem_req_valid),
      .imem_req_addr       (imem_req_addr),
      .imem_req_ready      (imem_req_ready),
      .imem_rsp_valid      (imem_rsp_valid),
      .imem_rsp_data       (imem_rsp_data),
      .redirect_valid      (redirect_valid),
      .redirect_addr       (redirect_addr),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_instr           (out_instr),
      .out_pc_plus4        (out_pc_plus4),
      .redirect_misaligned (redirect_misaligned)
   );

   // Inputs are applied in the cycle; expected values are the outputs seen
   // in that same cycle, before the inputs take effect at the rising edge.
   typedef struct {
      logic        rdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        rdv;
      logic [31:0] rda;
      logic        ordy;
      logic        rv;
      logic [31:0] ra;
      logic        ov;
      logic [31:0] oi;
      logic [31:0] opc;
      logic        mis;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] rspd,
                               input logic rdv, input logic [31:0] rda, input logic ordy,
                               input logic rv, input logic [31:0] ra, input logic ov,
                               input logic [31:0] oi, input logic [31:0] opc, input logic mis);
      vec_t v;
      v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.rdv = rdv; v.rda = rda; v.ordy = ordy;
      v.rv = rv; v.ra = ra; v.ov = ov; v.oi = oi; v.opc = opc; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_addr  = 32'h0;
      out_ready      = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0040_0000);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc4", out_pc_plus4, 32'h0);
      chk("rst_misaligned", {31'b0, redirect_misaligned}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0000, 0, 32'h0,         32'h0,         0);
      vecs[1]  = mk(0, 1, 32'hAAAA_0001, 0, 32'h0,         1, 0, 32'h0040_0000, 0, 32'h0,         32'h0,         0);
      vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0040_0004, 1, 32'hAAAA_0001, 32'h0040_0004, 0);
      vecs[3]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0004, 0, 32'hAAAA_0001, 32'h0040_0004, 0);
      vecs[4]  = mk(0, 1, 32'hBBBB_0002, 0, 32'h0,         1, 0, 32'h0040_0004, 0, 32'hAAAA_0001, 32'h0040_0004, 0);
      vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0040_0008, 1, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[6]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0008, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[7]  = mk(0, 0, 32'h0,         1, 32'h0040_0100, 1, 0, 32'h0040_0008, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0040_0100, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[9]  = mk(0, 1, 32'hDEAD_0000, 0, 32'h0,         1, 0, 32'h0040_0100, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[10] = mk(1, 0, 32'h0,         1, 32'h0040_0200, 1, 1, 32'h0040_0100, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[11] = mk(0, 1, 32'hDEAD_0001, 0, 32'h0,         1, 0, 32'h0040_0200, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[12] = mk(0, 0, 32'h0,         1, 32'h0040_0203, 1, 1, 32'h0040_0200, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[13] = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0200, 0, 32'hBBBB_0002, 32'h0040_0008, 1);
      vecs[14] = mk(0, 1, 32'hCCCC_0003, 0, 32'h0,         1, 0, 32'h0040_0200, 0, 32'hBBBB_0002, 32'h0040_0008, 0);
      vecs[15] = mk(0, 0, 32'h0,         1, 32'h0040_0300, 1, 0, 32'h0040_0204, 1, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[16] = mk(0, 1, 32'h0BAD_0BAD, 0, 32'h0,         1, 1, 32'h0040_0300, 0, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[17] = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0300, 0, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[18] = mk(0, 1, 32'hDEAD_0002, 1, 32'h0040_0400, 1, 0, 32'h0040_0300, 0, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[19] = mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0400, 0, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[20] = mk(0, 1, 32'h1111_0004, 0, 32'h0,         1, 0, 32'h0040_0400, 0, 32'hCCCC_0003, 32'h0040_0204, 0);
      vecs[21] = mk(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0040_0404, 1, 32'h1111_0004, 32'h0040_0404, 0);
      vecs[22] = mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0040_0404, 1, 32'h1111_0004, 32'h0040_0404, 0);
      vecs[23] = mk(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0040_0404, 0, 32'h1111_0004, 32'h0040_0404, 0);

      do_reset();
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         n_tests++;
         if ({imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, redirect_misaligned} !==
             {vecs[i].rv, vecs[i].ra, vecs[i].ov, vecs[i].oi, vecs[i].opc, vecs[i].mis}) begin
            n_fail++;
            $display("FAIL vec%0d: got rv=%b ra=%h ov=%b oi=%h opc=%h mis=%b, expected rv=%b ra=%h ov=%b oi=%h opc=%h mis=%b",
                     i, imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, redirect_misaligned,
                     vecs[i].rv, vecs[i].ra, vecs[i].ov, vecs[i].oi, vecs[i].opc, vecs[i].mis);
         end
         imem_req_ready = vecs[i].rdy;
         imem_rsp_valid = vecs[i].rspv;
         imem_rsp_data  = vecs[i].rspd;
         redirect_valid = vecs[i].rdv;
         redirect_addr  = vecs[i].rda;
         out_ready      = vecs[i].ordy;
      end

      // Decode stalls for 5 cycles in HOLD.
      do_reset();
      @(negedge clk);
      chk("stall_first_addr", imem_req_addr, 32'h0040_0000);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_out_instr", out_instr, 32'h1234_5678);
         chk("stall_out_pc4", out_pc_plus4, 32'h0040_0004);
         chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
         if (k < 4) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_next_req", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_next_addr", imem_req_addr, 32'h0040_0004);
      chk("stall_out_dropped", {31'b0, out_valid}, 32'd0);

      // Fetch at the top of the address space wraps pc+4 to zero.
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0055;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("wrap_out_valid", {31'b0, out_valid}, 32'd1);
      chk("wrap_out_pc4", out_pc_plus4, 32'h0000_0000);
      @(negedge clk);
      chk("wrap_next_req", {31'b0, imem_req_valid}, 32'd1);
      chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

      // Reset asserted while a request is outstanding.
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("midrst_in_wait", {31'b0, imem_req_valid}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("midrst_addr", imem_req_addr, 32'h0040_0000);
      chk("midrst_out_instr", out_instr, 32'h0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("postrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("postrst_addr", imem_req_addr, 32'h0040_0000);
      chk("postrst_late_rsp_ignored", {31'b0, out_valid}, 32'd0);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0077;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("postrst_out_instr", out_instr, 32'h0000_0077);
      chk("postrst_out_pc4", out_pc_plus4, 32'h0040_0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
